// File: rtl/idex_pipe_reg_pkg.sv
// Shared core definitions for the pipeline registers: destination-select encodings,
// instruction field positions and the fixed architectural register indices.
package idex_pipe_reg_pkg;

  typedef enum logic [1:0] {
    RegDstRd   = 2'b00,
    RegDstRt   = 2'b01,
    RegDstLink = 2'b10,
    RegDstXp   = 2'b11
  } reg_dst_e;

  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;
  localparam int unsigned RD_HI = 15;
  localparam int unsigned RD_LO = 11;
  localparam int unsigned SH_HI = 10;
  localparam int unsigned SH_LO = 6;

  localparam logic [4:0] DEFAULT_LINK_REG = 5'd31;
  localparam logic [4:0] DEFAULT_XP_REG   = 5'd26;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
    logic       alu_src1;
    logic       alu_src2;
    logic       sign;
    logic [1:0] mem_to_reg;
    logic [5:0] alu_fun;
  } ctrl_t;

endpackage

// File: rtl/idex_pipe_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; shared by the pipeline stages.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: captures decoded controls and operands, supports stall/flush,
// counts inserted bubbles and flags load-use hazards back to decode.
module idex_pipe_reg
  import idex_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter logic [4:0]  LINK_REG = DEFAULT_LINK_REG,
  parameter logic [4:0]  XP_REG   = DEFAULT_XP_REG,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              validin,
  input  logic [31:0]       instructionin,
  input  logic [DATA_W-1:0] DatabusAin,
  input  logic [DATA_W-1:0] DatabusBin,
  input  logic [DATA_W-1:0] immin,
  input  logic [DATA_W-1:0] PCplusin,
  input  logic [1:0]        RegDstin,
  input  logic              RegWrin,
  input  logic              MemWrin,
  input  logic              MemRdin,
  input  logic              ALUSrc1in,
  input  logic              ALUSrc2in,
  input  logic              Signin,
  input  logic [1:0]        MemtoRegin,
  input  logic [5:0]        ALUFunin,
  output logic [DATA_W-1:0] DatabusAout,
  output logic [DATA_W-1:0] DatabusBout,
  output logic [DATA_W-1:0] immout,
  output logic [DATA_W-1:0] PCplusout,
  output logic [1:0]        RegDstout,
  output logic              RegWrout,
  output logic              MemWrout,
  output logic              MemRdout,
  output logic              ALUSrc1out,
  output logic              ALUSrc2out,
  output logic              Signout,
  output logic [1:0]        MemtoRegout,
  output logic [5:0]        ALUFunout,
  output logic              validout,
  output logic [4:0]        shamt,
  output logic [4:0]        Rsout,
  output logic [4:0]        Rtout,
  output logic [4:0]        Rdout,
  output logic              loaduse,
  output logic [CNT_W-1:0]  bubblecount
);

  logic              valid_d, valid_q;
  ctrl_t             ctrl_d, ctrl_q, ctrl_in;
  logic [DATA_W-1:0] a_d, a_q, b_d, b_q, imm_d, imm_q, pc_d, pc_q;
  logic [4:0]        shamt_d, shamt_q, rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [4:0]        rd_dec;
  logic              bubble;
  logic              unused_instr;

  assign unused_instr = ^{instructionin[31:26], instructionin[5:0]};

  // Flush beats stall; an unstalled load of a non-valid instruction is also a bubble.
  assign bubble = flush | (~stall & ~validin);

  assign ctrl_in = '{
    reg_dst:    RegDstin,
    reg_wr:     RegWrin,
    mem_wr:     MemWrin,
    mem_rd:     MemRdin,
    alu_src1:   ALUSrc1in,
    alu_src2:   ALUSrc2in,
    sign:       Signin,
    mem_to_reg: MemtoRegin,
    alu_fun:    ALUFunin
  };

  always_comb begin
    rd_dec = instructionin[RD_HI:RD_LO];
    unique case (reg_dst_e'(RegDstin))
      RegDstRd:   rd_dec = instructionin[RD_HI:RD_LO];
      RegDstRt:   rd_dec = instructionin[RT_HI:RT_LO];
      RegDstLink: rd_dec = LINK_REG;
      RegDstXp:   rd_dec = XP_REG;
      default:    rd_dec = instructionin[RD_HI:RD_LO];
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    shamt_d = shamt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    if (bubble) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      pc_d    = '0;
      shamt_d = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
    end else if (!stall) begin
      valid_d = validin;
      ctrl_d  = ctrl_in;
      a_d     = DatabusAin;
      b_d     = DatabusBin;
      imm_d   = immin;
      pc_d    = PCplusin;
      shamt_d = instructionin[SH_HI:SH_LO];
      rs_d    = instructionin[RS_HI:RS_LO];
      rt_d    = instructionin[RT_HI:RT_LO];
      rd_d    = rd_dec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      shamt_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      shamt_q <= shamt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_bubble_cnt (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (bubble),
    .count_o (bubblecount)
  );

  assign DatabusAout = a_q;
  assign DatabusBout = b_q;
  assign immout      = imm_q;
  assign PCplusout   = pc_q;
  assign RegDstout   = ctrl_q.reg_dst;
  assign RegWrout    = ctrl_q.reg_wr;
  assign MemWrout    = ctrl_q.mem_wr;
  assign MemRdout    = ctrl_q.mem_rd;
  assign ALUSrc1out  = ctrl_q.alu_src1;
  assign ALUSrc2out  = ctrl_q.alu_src2;
  assign Signout     = ctrl_q.sign;
  assign MemtoRegout = ctrl_q.mem_to_reg;
  assign ALUFunout   = ctrl_q.alu_fun;
  assign validout    = valid_q;
  assign shamt       = shamt_q;
  assign Rsout       = rs_q;
  assign Rtout       = rt_q;
  assign Rdout       = rd_q;

  // $0 is never a real destination, so a write to it cannot create a hazard.
  assign loaduse = valid_q & ctrl_q.mem_rd & ctrl_q.reg_wr & (rd_q != 5'd0) &
                   ((rd_q == instructionin[RS_HI:RS_LO]) | (rd_q == instructionin[RT_HI:RT_LO]));

endmodule

// File: doc/idex_pipe_reg.md
# idex_pipe_reg

Parametrised ID/EX pipeline register for the five-stage MIPS core, sitting between decode/register-read and the ALU stage. It captures decoded control, operands and register fields each cycle, and supports three further behaviours:
- stall (hold) and flush (bubble insertion), with defined priority;
- a per-stage valid bit and a saturating bubble counter;
- a registered-destination load-use hazard detector that drives the decode-stage stall.

## Interface
Parameters:
- DATA_W, 32: width of operand, immediate and PC+4 buses.
- LINK_REG, 31: destination index written when RegDstin = 2'b10.
- XP_REG, 26: destination index written when RegDstin = 2'b11 (exception return register).
- CNT_W, 16: bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold all stage contents this cycle.
- flush  in  1  replace stage contents with a bubble this cycle.
- validin  in  1  the instruction presented by decode is real.
- instructionin  in  32  raw instruction word from ID.
- DatabusAin, DatabusBin, immin, PCplusin  in  DATA_W each  operands, extended immediate, PC+4.
- RegDstin  in  2  destination select: 00 rd, 01 rt, 10 LINK_REG, 11 XP_REG.
- RegWrin, MemWrin, MemRdin, ALUSrc1in, ALUSrc2in, Signin  in  1 each  decoded controls.
- MemtoRegin  in  2.
- ALUFunin  in  6.
- Same-named ...out registers for every control and data input above  out  same widths.
- validout  out  1  stage holds a real instruction.
- shamt, Rsout, Rtout, Rdout  out  5 each  instruction[10:6], [25:21], [20:16], and the decoded destination.
- loaduse  out  1  combinational hazard request to ID.
- bubblecount  out  CNT_W  saturating count of bubbles entering the stage.

## Operation
- Update rule, evaluated on each rising edge. Priority: reset > flush > stall > load.
- Load:
  - All ...out registers take their ...in values.
  - Rs/Rt/shamt are sliced from instructionin.
  - Rdout is decoded from RegDstin.
  - validout <= validin.
- Bubble: occurs on flush, or on a load with validin = 0.
  - validout, RegWrout, MemWrout and MemRdout <= 0.
  - MemtoRegout and ALUFunout <= 0.
  - All other outputs <= 0 for determinism.
  - A bubble must never produce a register or memory write downstream.
- Stall without flush: every register, including bubblecount, holds.
- flush and stall together: flush wins and a bubble is inserted.
- bubblecount increments by 1 on every bubble edge. It saturates at all-ones and never wraps. A held stall does not count.
- loaduse = validout & MemRdout & RegWrout & (Rdout != 0) & (Rdout == instructionin[25:21] | Rdout == instructionin[20:16]).
  - Purely combinational from registered state and instructionin.
  - ID is responsible for combining it with its own stall/flush.
- Reset (asynchronous assert, synchronous-safe deassert at the system level): every output register is cleared to 0, so validout = 0, Rdout = 0 and bubblecount = 0.

## Timing
- Latency: 1 cycle from inputs to outputs on a load edge.
- loaduse is valid in the same cycle as the consumer instruction sits on instructionin. The expected response is a one-cycle ID stall plus a flush of this stage on the next edge.
- Reset asserted mid-stall or mid-flush: outputs clear immediately, without waiting for clk.
- Output fields depend only on the registered RegDstin. There is no combinational path from any input to any ...out register output.
- Rdout = 0 with RegWrout = 1 is legal and carries no hazard.

## Structure
- The shared core package holds:
  - the RegDst encodings (RD, RT, LINK, XP);
  - the instruction field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO, SH_HI/LO);
  - the default LINK_REG and XP_REG values.
- One natural sub-module, sat_counter (CNT_W wide, enable, async active-low clear), which the later EX/MEM and MEM/WB stages reuse.
- The destination decode and the loaduse compare stay inline.

## Test plan
- Reset with reset = 0 mid-cycle while outputs are loaded → all outputs read 0 before the next clk edge. After release, validout stays 0 until the first load.
- Load instructionin = 0x012A4020 (add $8,$9,$10), RegDstin = 00, validin = 1 → next edge gives Rsout = 9, Rtout = 10, Rdout = 8, validout = 1. Then RegDstin = 10 → Rdout = 31; RegDstin = 11 → Rdout = 26.
- Assert stall for 3 cycles while the inputs change → outputs and bubblecount are unchanged. Raise flush during the second of those cycles → validout = 0, RegWrout = 0, MemWrout = 0 and bubblecount += 1.
- Stage holds lw $8 (MemRdout = RegWrout = 1, Rdout = 8); present add $9,$8,$1 → loaduse = 1. Present add $9,$2,$1 → loaduse = 0. With Rdout = 0, the same pattern gives loaduse = 0.
- Force bubblecount to all-ones minus 1 with CNT_W = 4, then apply 3 bubble edges → counter reads 15 and stays 15.
- Load with validin = 0 and RegWrin = MemWrin = 1 → validout = RegWrout = MemWrout = 0 and bubblecount increments.
